fps_rate_decoder: RTL



---
 rtl/fps_rate_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fps_rate_decoder.sv
// fps_rate_decoder: measures the frame tick period, decodes it back to the
// 4-bit frame-rate select code, tracks lock, and counts ticks per window.
// Optional build macro FPS_JITTER_STATS_EN adds min/max period tracking
// while locked; without it period_min/period_max are constants.
//
// state   | meaning
// IDLE    | no reference tick seen yet (after reset or a timeout)
// ACQUIRE | ticking, waiting for LOCK_COUNT matching periods
// LOCKED  | consecutive periods agree on one recognised code
module fps_rate_decoder #(
  parameter int unsigned LOCK_COUNT     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned WINDOW_CYCLES  = 50000000,
  // nominal period of code k is CLOCK_HZ / fps_k + 1 clocks
  parameter int unsigned CLOCK_HZ       = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  output logic [3:0]  detected_frame_rate,
  output logic        rate_valid,
  output logic [26:0] measured_period,
  output logic [6:0]  fps_count,
  output logic        timeout,
  output logic [26:0] period_min,
  output logic [26:0] period_max
);

  localparam logic [26:0] CNT_MAX     = '1;
  localparam logic [26:0] TIMEOUT_CNT = 27'(TIMEOUT_CYCLES);
  localparam logic [3:0]  NO_CODE     = 4'b1111;
  localparam logic [3:0]  LOCK_RUN    = 4'(LOCK_COUNT);
  localparam int          WIN_W       = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t           state;
  logic [26:0]      cnt;
  logic [3:0]       cand;
  logic [3:0]       run;
  logic [3:0]       code;
  logic [3:0]       run_next;
  logic             lock_next;
  logic [26:0]      nom;
  logic [26:0]      diff;
  logic [WIN_W-1:0] win_cnt;
  logic [6:0]       tick_cnt;
  logic [6:0]       tick_inc;

  function automatic logic [26:0] nominal_period(input int k);
    int unsigned fps;
    case (k)
      0:       fps = 1;
      1:       fps = 5;
      2:       fps = 10;
      3:       fps = 15;
      4:       fps = 20;
      5:       fps = 25;
      6:       fps = 30;
      7:       fps = 35;
      8:       fps = 40;
      9:       fps = 45;
      10:      fps = 50;
      11:      fps = 55;
      default: fps = 60;
    endcase
    return 27'(CLOCK_HZ / fps + 1);
  endfunction

  // Classify the running count against every code's +/- 1/32 window
  always_comb begin
    code = NO_CODE;
    nom  = '0;
    diff = '0;
    for (int k = 0; k < 13; k++) begin
      nom  = nominal_period(k);
      diff = (cnt >= nom) ? (cnt - nom) : (nom - cnt);
      if (diff <= (nom >> 5)) code = 4'(k);
    end
  end

  // Run-length of matching codes and whether this tick leaves us locked
  always_comb begin
    if (code == cand) run_next = (run < LOCK_RUN) ? (run + 4'd1) : run;
    else              run_next = 4'd1;
    if (state == LOCKED) lock_next = (code == cand);
    else                 lock_next = (run_next == LOCK_RUN) && (code != NO_CODE);
  end

  // Period counter, lock FSM and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      cand                <= NO_CODE;
      run                 <= '0;
      detected_frame_rate <= NO_CODE;
      rate_valid          <= 1'b0;
      measured_period     <= '0;
      timeout             <= 1'b0;
    end else begin
      if (frame_tick)          cnt <= 27'd1;
      else if (cnt != CNT_MAX) cnt <= cnt + 27'd1;

      if (frame_tick) begin
        timeout <= 1'b0;
        if (state == IDLE) begin
          state <= ACQUIRE;
        end else begin
          measured_period     <= cnt;
          detected_frame_rate <= code;
          cand                <= code;
          run                 <= run_next;
          state               <= lock_next ? LOCKED : ACQUIRE;
          rate_valid          <= lock_next;
        end
      end else if (state != IDLE && cnt == TIMEOUT_CNT) begin
        state               <= IDLE;
        rate_valid          <= 1'b0;
        timeout             <= 1'b1;
        detected_frame_rate <= NO_CODE;
        run                 <= '0;
        cand                <= NO_CODE;
      end
    end
  end

  assign tick_inc = (frame_tick && tick_cnt != 7'h7f) ? (tick_cnt + 7'd1) : tick_cnt;

  // Gate window: publish the tick total (incl. a last-cycle tick) each window
  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt   <= '0;
      tick_cnt  <= '0;
      fps_count <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt   <= '0;
      tick_cnt  <= '0;
      fps_count <= tick_inc;
    end else begin
      win_cnt  <= win_cnt + 1'b1;
      tick_cnt <= tick_inc;
    end
  end

`ifdef FPS_JITTER_STATS_EN
  // Jitter stats: seeded by the locking tick, widened by each locked tick
  always_ff @(posedge clock) begin
    if (reset) begin
      period_min <= '1;
      period_max <= '0;
    end else if (frame_tick && lock_next) begin
      if (state == ACQUIRE) begin
        period_min <= cnt;
        period_max <= cnt;
      end else if (state == LOCKED) begin
        if (cnt < period_min) period_min <= cnt;
        if (cnt > period_max) period_max <= cnt;
      end
    end
  end
`else
  assign period_min = '1;
  assign period_max = '0;
`endif

endmodule
